// File: rtl/seg_display_driver_pkg.sv
// seg_display_driver_pkg: active-low segment codes, converter states, prescaler divide and digit decode helpers
package seg_display_driver_pkg;
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_e;
  function automatic int calc_div(input int clk_hz, input int scan_hz);
    return clk_hz / scan_hz;
  endfunction
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction
endpackage

// File: rtl/seg_display_driver_bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter; ports clk, reset (async active-low), value in, bcd out (nibble 0 = units), busy out
module bin2bcd_seq
  import seg_display_driver_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      value,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);
  localparam int CW = $clog2(WIDTH + 1);
  conv_state_e state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n, last_value, last_n;
  logic [4*DIGITS-1:0] work, work_n, adj, bcd_n;
  logic [CW-1:0] cnt, cnt_n;
  logic busy_n;
  always_comb begin
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = work[4*i +: 4] >= 4'd5 ? work[4*i +: 4] + 4'd3 : work[4*i +: 4];
    state_n = state;
    shreg_n = shreg;
    work_n = work;
    cnt_n = cnt;
    last_n = last_value;
    bcd_n = bcd;
    busy_n = busy;
    case (state)
      IDLE: if (value != last_value) begin
        state_n = SHIFT;
        shreg_n = value;
        last_n = value;
        work_n = '0;
        cnt_n = '0;
        busy_n = 1'b1;
      end
      SHIFT: begin
        {work_n, shreg_n} = {adj, shreg} << 1;
        cnt_n = cnt + CW'(1);
        state_n = cnt == CW'(WIDTH - 1) ? DONE : SHIFT;
      end
      DONE: begin
        bcd_n = work;
        busy_n = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      shreg <= '0;
      work <= '0;
      cnt <= '0;
      last_value <= '0;
      bcd <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_n;
      shreg <= shreg_n;
      work <= work_n;
      cnt <= cnt_n;
      last_value <= last_n;
      bcd <= bcd_n;
      busy <= busy_n;
    end
endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: decimal 7-seg scan driver; ports clk, reset (async active-low), value in, an/seg out (active-low), bcd/busy out
module seg_display_driver
  import seg_display_driver_pkg::*;
#(
  parameter int CLK_HZ   = 50000000,
  parameter int SCAN_HZ  = 1000,
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    value,
  output logic [DIGITS-1:0]   an,
  output logic [6:0]          seg,
  output logic [4*DIGITS-1:0] bcd,
  output logic                busy
);
  localparam int DIV = calc_div(CLK_HZ, SCAN_HZ);
  localparam int PW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  logic [PW-1:0] pre;
  logic [IW-1:0] idx, cur, sel;
  logic tick, on, lz;
  logic [3:0] dig;
  logic [6:0] seg_n;
  bin2bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) u_conv (
    .clk(clk), .reset(reset), .value(value), .bcd(bcd), .busy(busy)
  );
  // idx is the digit to show on the next tick; cur is the one currently shown,
  // so the first tick after reset lights the units digit.
  always_comb begin
    tick = pre == PW'(DIV - 1);
    sel = tick ? idx : cur;
    dig = bcd[4*sel +: 4];
    lz = BLANK_LZ && sel != '0 && (bcd >> (4*sel)) == '0;
    seg_n = lz ? SEG_BLANK : seg_decode(dig);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      pre <= '0;
      idx <= '0;
      cur <= '0;
      on <= 1'b0;
      an <= '1;
      seg <= SEG_BLANK;
    end else begin
      pre <= tick ? '0 : pre + PW'(1);
      if (tick) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
      cur <= sel;
      on <= on | tick;
      if (on | tick) begin
        an <= ~(DIGITS'(1) << sel);
        seg <= seg_n;
      end
    end
endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: directed self-checking bench for seg_display_driver
module tb_seg_display_driver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [7:0] value = 8'd0;
  logic [2:0] an, an2;
  logic [6:0] seg, seg2;
  logic [11:0] bcd, bcd2;
  logic busy, busy2;
  int errors = 0;
  int checks = 0;
  int n;
  logic [2:0] prev;
  logic hit;
  always #5 clk = ~clk;
  seg_display_driver #(.CLK_HZ(1000), .SCAN_HZ(100), .WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .value(value), .an(an), .seg(seg), .bcd(bcd), .busy(busy)
  );
  seg_display_driver #(.CLK_HZ(1000), .SCAN_HZ(100), .WIDTH(8), .DIGITS(3), .BLANK_LZ(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .value(value), .an(an2), .seg(seg2), .bcd(bcd2), .busy(busy2)
  );
  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_an(input logic [2:0] target);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (an === target) hit = 1'b1;
      else cyc(1);
    end
    chk("an_reached", {29'd0, an}, {29'd0, target});
  endtask
  initial begin
    cyc(3);
    chk("rst_an", an, 3'b111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_bcd", bcd, 12'h000);
    chk("rst_busy", busy, 1'b0);
    reset = 1'b1;
    cyc(9);
    chk("pre_tick_an", an, 3'b111);
    cyc(1);
    chk("first_tick_an", an, 3'b110);
    chk("first_tick_seg", seg, 7'h40);
    value = 8'd255;
    n = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      if (busy) n++;
    end
    chk("busy_cycles", n, 9);
    chk("bcd_before", bcd, 12'h000);
    cyc(1);
    chk("bcd_255", bcd, 12'h255);
    chk("busy_done", busy, 1'b0);
    wait_an(3'b110);
    chk("seg_255_u", seg, 7'h12);
    wait_an(3'b101);
    chk("seg_255_t", seg, 7'h12);
    wait_an(3'b011);
    chk("seg_255_h", seg, 7'h24);
    value = 8'd7;
    cyc(12);
    chk("bcd_7", bcd, 12'h007);
    wait_an(3'b110);
    chk("seg_7_u", seg, 7'h78);
    chk("seg_7_u_nb", seg2, 7'h78);
    wait_an(3'b101);
    chk("seg_7_t", seg, 7'h7F);
    chk("seg_7_t_nb", seg2, 7'h40);
    wait_an(3'b011);
    chk("seg_7_h", seg, 7'h7F);
    chk("seg_7_h_nb", seg2, 7'h40);
    value = 8'd100;
    cyc(2);
    value = 8'd101;
    cyc(8);
    chk("bcd_100", bcd, 12'h100);
    chk("busy_100_done", busy, 1'b0);
    cyc(1);
    chk("busy_restart", busy, 1'b1);
    cyc(8);
    chk("bcd_101_pending", bcd, 12'h100);
    cyc(1);
    chk("bcd_101", bcd, 12'h101);
    wait_an(3'b110);
    prev = an;
    n = 0;
    while (an === prev && n < 30) begin
      cyc(1);
      n++;
    end
    chk("period_u", n, 10);
    chk("next_t", an, 3'b101);
    prev = an;
    n = 0;
    while (an === prev && n < 30) begin
      cyc(1);
      n++;
    end
    chk("period_t", n, 10);
    chk("next_h", an, 3'b011);
    prev = an;
    n = 0;
    while (an === prev && n < 30) begin
      cyc(1);
      n++;
    end
    chk("period_h", n, 10);
    chk("wrap_u", an, 3'b110);
    value = 8'd200;
    cyc(3);
    chk("busy_shift", busy, 1'b1);
    reset = 1'b0;
    #1;
    chk("mid_rst_an", an, 3'b111);
    chk("mid_rst_seg", seg, 7'h7F);
    chk("mid_rst_bcd", bcd, 12'h000);
    chk("mid_rst_busy", busy, 1'b0);
    cyc(2);
    reset = 1'b1;
    n = 0;
    while (bcd !== 12'h200 && n < 11) begin
      cyc(1);
      n++;
    end
    chk("bcd_200", bcd, 12'h200);
    chk("bcd_200_latency", n, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/seg_display_driver.md
Name: seg_display_driver

Overview:
- Consumer of the 8-bit up/down counter value `q`; shows it in decimal on a multiplexed, common-anode 7-segment display (3 digits, 0–255).
- A sequential double-dabble converter turns the binary value into BCD.
- A prescaled scan engine time-multiplexes the anodes and drives the segments.
- Sits between the counter FSM and the board display pins.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- SCAN_HZ, 1000, digit-advance rate in Hz. DIV = CLK_HZ/SCAN_HZ.
- WIDTH, 8, binary input width.
- DIGITS, 3, number of BCD digits / anodes (must cover 2^WIDTH-1).
- BLANK_LZ, 1, 1 = blank leading zeros.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- value  in  WIDTH  binary value to display (from counter `q`).
- an  out  DIGITS  anode enables, active-low, one-hot-low; bit 0 = units.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- bcd  out  4*DIGITS  last completed BCD result; nibble 0 = units.
- busy  out  1  high while a conversion is in progress.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - an = all ones, seg = 7'h7F, bcd = 0, busy = 0.
  - Converter state = IDLE, last_value = 0, scan index = 0, prescaler = 0.
- Converter FSM, states IDLE / SHIFT / DONE:
  - IDLE: if value != last_value, latch value into shift reg and last_value, clear work BCD, busy=1, go to SHIFT.
  - SHIFT: runs exactly WIDTH cycles. Each cycle, add 3 to every work nibble >= 5, then shift {bcd_work, shreg} left by 1. After the WIDTH-th shift, go to DONE.
  - DONE: bcd <= bcd_work, busy=0, go to IDLE.
- Latency: value change at edge N gives bcd valid at edge N+WIDTH+2, i.e. 10 cycles for WIDTH=8.
- value changes during SHIFT/DONE are ignored. On return to IDLE the comparison against last_value restarts a conversion on the next cycle, so the final value is always displayed.
- Nibble arithmetic is 4-bit. Only legal BCD results are produced for value <= 2^WIDTH-1.
- Scan prescaler:
  - Counts 0..DIV-1; the tick fires on DIV-1, then the counter wraps to 0.
  - On tick, the index advances 0→1→…→DIGITS-1→0.
- an and seg are registered. Both update on the same edge (index change or bcd change), giving no ghosting cycle.
- First tick after reset loads an = ~(1<<index).
- Segment decode, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Any non-BCD nibble decodes to blank (7F).
- Leading-zero blanking (BLANK_LZ=1):
  - Digit k>0 shows blank (seg=7F, anode still scanned) if it and all higher digits are 0.
  - Units digit is never blanked.
- Reset mid-conversion or mid-scan: immediate return to the reset values above. A conversion of the current value starts only if it is nonzero.

Decomposition:
- Shared package holds:
  - Segment code constants SEG_0..SEG_9 and SEG_BLANK.
  - Converter state typedef (IDLE, SHIFT, DONE).
  - Function computing DIV.
- Sub-module bin2bcd_seq holds the converter FSM, with ports clk, reset, value, bcd, busy.
- seg_display_driver instantiates bin2bcd_seq and implements the prescaler, scan and decode.

Test Plan (CLK_HZ=1000, SCAN_HZ=100 → DIV=10):
- Reset held low, value=8'd0 → an=3'b111, seg=7F, bcd=0, busy=0. After release and first tick: an=3'b110, seg=40.
- value 0→8'd255 → busy high for 9 cycles; bcd=12'h255 exactly 10 cycles after the change. Scan shows seg 12/12/24 on an=110/101/011.
- value=8'd7, BLANK_LZ=1 → units seg=78; tens and hundreds seg=7F while their anodes are low. Repeat with BLANK_LZ=0: 40,40.
- value=8'd100 then 8'd101 two cycles later → first conversion completes with bcd=12'h100. Second conversion starts the next cycle; final bcd=12'h101.
- Scan timing: measure anode period. Each anode is low for exactly 10 cycles; sequence 110→101→011→110 wraps.
- Assert reset during SHIFT (value=8'd200) → outputs return to reset values immediately. After release: bcd=12'h200 within 11 cycles.
